lab61_soc_pio_edge: RTL

LAB61_SOC_PIO_EDGE -- requirements
Module: lab61_soc_pio_edge

---
 rtl/lab61_pio_pkg.sv | 19 +
 rtl/lab61_pio_debounce.sv | 71 +++++++
 rtl/lab61_soc_pio_edge.sv | 104 ++++++++++
 3 files changed

// File: rtl/lab61_pio_pkg.sv
// Shared constants for the edge-capturing PIO: Avalon-MM register addresses
// and the capture-mode encoding used by the EDGE_TYPE parameter.
`timescale 1ns/1ps
package lab61_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_mode_e;

endpackage

// File: rtl/lab61_pio_debounce.sv
// One input bit: 2-flop synchronizer, followed by a stable-count debounce filter
// when PIO_DEBOUNCE_EN is defined (otherwise the synchronized bit passes straight out).
`timescale 1ns/1ps
module lab61_pio_debounce
  import lab61_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  logic [15:0] count_q, count_d;
  logic        filt_q, filt_d;

  // The count only advances while the synchronized bit disagrees with the
  // filtered one; any agreement drops it back to zero.
  always_comb begin
    filt_d  = filt_q;
    count_d = '0;
    if (sync_q != filt_q) begin
      if (count_q == 16'(DEBOUNCE_CYCLES - 1)) begin
        filt_d  = sync_q;
        count_d = '0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      filt_q  <= filt_d;
      count_q <= count_d;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q;
`endif

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_cfg_check
    $error("lab61_pio_debounce: DEBOUNCE_CYCLES out of range 2..65535");
  end

endmodule

// File: rtl/lab61_soc_pio_edge.sv
// Avalon-MM edge-capture PIO with level interrupt. Optional input debounce is
// compiled in with macro PIO_DEBOUNCE_EN (see lab61_pio_debounce).
`timescale 1ns/1ps
module lab61_soc_pio_edge
  import lab61_pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_TYPE[1:0]);

  // Bus handshake: no waitrequest. A write is taken on any clock with
  // write=1; readdata reflects the address presented one clock earlier.

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lab61_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[i]),
      .dout (data_in[i])
    );
  end

  always_comb begin
    rise = data_in & ~prev_q;
    fall = ~data_in & prev_q;
    case (MODE)
      EDGE_RISING:  edge_det = rise;
      EDGE_FALLING: edge_det = fall;
      default:      edge_det = rise | fall;
    endcase
  end

  always_comb begin
    prev_d    = data_in;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (write && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (write && address == ADDR_EDGECAP) begin
      edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a same-cycle edge keeps its bit set.
    edgecap_d = edgecap_d | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

  if (WIDTH < 1 || WIDTH > DATA_W) begin : g_cfg_check
    $error("lab61_soc_pio_edge: WIDTH out of range 1..32");
  end

endmodule
